// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: receiver FSM state encoding, default frame
// parameters and the system clock frequency shared with the baud generator.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_pkg;

  localparam int          UART_DATA_BITS  = 8;
  localparam int          UART_OVERSAMPLE = 16;
  localparam int unsigned CLK_HZ          = 150_000_000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_oversample_if.sv
// -----------------------------------------------------------------------------
// uart_rx_oversample_if
// Groups the receiver's serial-side inputs and byte-side outputs.
//   rx_tick    : sample strobe from the baud generator (OVERSAMPLE x baud)
//   rx_in      : raw serial line, idle high
//   rx_data    : last good byte
//   rx_valid   : one-clk good-frame strobe
//   frame_err  : one-clk stop-bit-low strobe
//   parity_err : one-clk parity-mismatch strobe
//   rx_busy    : receiver is inside a frame
// Modports: slave = the receiver, master = line/tick source and byte consumer.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface uart_rx_oversample_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);
  logic                 rx_tick;
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 rx_busy;

  modport slave (
    input  rx_tick, rx_in,
    output rx_data, rx_valid, frame_err, parity_err, rx_busy
  );

  modport master (
    output rx_tick, rx_in,
    input  rx_data, rx_valid, frame_err, parity_err, rx_busy
  );
endinterface

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   reset : asynchronous, active-high; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output, 2 clk latency
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx_oversample.sv
// -----------------------------------------------------------------------------
// uart_rx_oversample
// Oversampling UART receiver. Synchronizes rx_in, qualifies the start bit at
// mid-bit, shifts DATA_BITS data bits in LSB first, checks the stop bit and
// emits a one-clk rx_valid or error strobe.
// Ports:
//   clk   : system clock (150 MHz)
//   reset : asynchronous, active-high
//   bus   : uart_rx_oversample_if.slave (rx_tick, rx_in in; rx_data,
//           rx_valid, frame_err, parity_err, rx_busy out)
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit; otherwise parity_err is tied 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_rx_oversample_if.slave   bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx_in),
    .q     (rx_s)
  );

  uart_state_e          state_q,    state_d;
  logic                 armed_q,    armed_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q,  bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic [DATA_BITS-1:0] data_q,     data_d;
  logic                 valid_q,    valid_d;
  logic                 ferr_q,     ferr_d;
  logic                 busy_q,     busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_flag_q, par_flag_d;
  logic                 perr_q,     perr_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_flag_q <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_flag_q <= par_flag_d;
      perr_q     <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_flag_d = par_flag_q;
    perr_d     = 1'b0;
`endif

    if (bus.rx_tick) begin
      unique case (state_q)
        IDLE: begin
          // A start edge only counts once the line has been seen idle-high,
          // so a stuck-low line cannot generate back-to-back frames.
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          if (tick_cnt_q == HALF_M1) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = DATA;
              bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              par_flag_d = 1'b0;
`endif
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            par_flag_d = (^shift_q) ^ rx_s;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            if (rx_s) begin
              // Good stop bit re-arms at once so a start bit that directly
              // follows is caught.
              armed_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              if (par_flag_q) begin
                perr_d = 1'b1;
              end else begin
                valid_d = 1'b1;
                data_d  = shift_q;
              end
`else
              valid_d = 1'b1;
              data_d  = shift_q;
`endif
            end else begin
              ferr_d  = 1'b1;
              armed_d = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.rx_busy   = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
